div_iter: RTL

Parametrised iterative radix-2 integer divider for the EX-stage multi-cycle unit, replacing the fixed 32-bit divider. It produces one quotient bit per cycle for a WIDTH-bit signed or unsigned division. Its operand handshake matches the existing divider: `o_ready`/`i_start`/`i_cancel`. It adds a divide-by-zero flag, deterministic results for every corner case, a registered result held until the next accepted start, and back-to-back issue.

---
 rtl/div_iter.sv | 77 +++++++
 1 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, signed/unsigned, one quotient bit per cycle.
// Result is {remainder, quotient}; divide-by-zero short-circuits straight to DONE.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_signed,
    input  logic [WIDTH-1:0]   i_op_data_0,
    input  logic [WIDTH-1:0]   i_op_data_1,
    input  logic               i_cancel,
    output logic [2*WIDTH-1:0] o_result,
    output logic               o_done,
    output logic               o_div_by_zero,
    output logic               o_ready
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] dvd, dvs, rem, a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0] trial;
    logic [CW-1:0] cnt;
    logic neg_q, neg_r, accept, zero, borrow;
    assign o_ready = state == IDLE || state == DONE;
    assign o_done = state == DONE;
    assign accept = o_ready && i_start && !i_cancel;
    assign zero = i_op_data_1 == '0;
    assign a_mag = i_signed && i_op_data_0[WIDTH-1] ? -i_op_data_0 : i_op_data_0;
    assign b_mag = i_signed && i_op_data_1[WIDTH-1] ? -i_op_data_1 : i_op_data_1;
    // rem < dvs always holds, so the top bit of the (WIDTH+1)-bit difference is the borrow
    assign trial = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
    assign borrow = trial[WIDTH];
    assign q_fix = neg_q ? -dvd : dvd;
    assign r_fix = neg_r ? -rem : rem;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = accept ? (zero ? DONE : CALC) : IDLE;
            CALC:       state_nxt = i_cancel ? IDLE : (cnt == '0 ? FIX : CALC);
            FIX:        state_nxt = i_cancel ? IDLE : DONE;
            default:    state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            o_result <= '0;
            o_div_by_zero <= 1'b0;
        end else if (accept && zero) begin
            o_result <= {i_op_data_0, {WIDTH{1'b1}}};
            o_div_by_zero <= 1'b1;
        end else if (accept) begin
            dvd <= a_mag;
            dvs <= b_mag;
            rem <= '0;
            cnt <= CW'(WIDTH - 1);
            neg_q <= i_signed && (i_op_data_0[WIDTH-1] ^ i_op_data_1[WIDTH-1]);
            neg_r <= i_signed && i_op_data_0[WIDTH-1];
        end else if (state == CALC) begin
            rem <= borrow ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], !borrow};
            cnt <= cnt - 1'b1;
        end else if (state == FIX && !i_cancel) begin
            o_result <= {r_fix, q_fix};
            o_div_by_zero <= 1'b0;
        end
    end
endmodule
